// File: rtl/rf_sum_ctrl_pkg.sv
// Shared constants and FSM encoding for the register-file summing controller.
package rf_sum_ctrl_pkg;

  localparam int unsigned NUM_REGS  = 23;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned RF_ADDR_W = 16;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StDrain = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Zero-extend a register index onto the register-file address bus.
  function automatic logic [RF_ADDR_W-1:0] rf_addr(input logic [IDX_W-1:0] idx);
    return {{(RF_ADDR_W - IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/rf_acc64.sv
// 64-bit accumulator with synchronous clear, add enable and sticky carry-out.
module rf_acc64 (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                clear,
  input  logic                                add_en,
  input  logic [rf_sum_ctrl_pkg::DATA_W-1:0]  add_data,
  output logic [rf_sum_ctrl_pkg::DATA_W-1:0]  sum,
  output logic                                carry
);
  import rf_sum_ctrl_pkg::*;

  logic [DATA_W-1:0] sum_q;
  logic              carry_q;
  logic [DATA_W:0]   full_sum;

  // One extra bit captures the carry out of the top data bit.
  assign full_sum = {1'b0, sum_q} + {1'b0, add_data};

  // Accumulator and sticky carry; clear wins over add.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (clear) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (add_en) begin
      sum_q   <= full_sum[DATA_W-1:0];
      carry_q <= carry_q | full_sum[DATA_W];
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: rtl/rf_sum_ctrl.sv
// Sums a run of consecutive register-file entries and writes the result back.
module rf_sum_ctrl #(
  parameter int unsigned NUM_REGS = rf_sum_ctrl_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = rf_sum_ctrl_pkg::DATA_W
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic [4:0]                            src_base,
  input  logic [4:0]                            count,
  input  logic [4:0]                            dst,
  output logic [rf_sum_ctrl_pkg::RF_ADDR_W-1:0] Addr,
  output logic                                  we,
  output logic [DATA_W-1:0]                     wData,
  input  logic [DATA_W-1:0]                     rData,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic                                  ovf
);
  import rf_sum_ctrl_pkg::*;

  localparam logic [5:0] NumRegsW = 6'(NUM_REGS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] src_q, cnt_q, dst_q, idx_q;
  logic             err_q;
  logic [IDX_W-1:0] rd_idx;
  logic             req_ok, accept, reject, last_rd, add_en;
  logic [DATA_W-1:0] acc_sum;

  // Range check: the last operand index src_base+count-1 must stay below NUM_REGS.
  assign req_ok = (count != 5'd0) &&
                  (({1'b0, src_base} + {1'b0, count}) <= NumRegsW) &&
                  ({1'b0, dst} < NumRegsW);
  assign accept  = (state_q == StIdle) && start && req_ok;
  assign reject  = (state_q == StIdle) && start && !req_ok;
  assign last_rd = (idx_q == cnt_q - 5'd1);
  assign rd_idx  = src_q + idx_q;

  // rData lags Addr by one cycle, so the first READ cycle has nothing to add yet.
  assign add_en = ((state_q == StRead) && (idx_q != '0)) || (state_q == StDrain);

  rf_acc64 u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .add_en   (add_en),
    .add_data (rData[DATA_W-1:0]),
    .sum      (acc_sum),
    .carry    (ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  if (last_rd) state_d = StDrain;
      StDrain: state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request fields, read index and the registered reject pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
      cnt_q <= '0;
      dst_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        src_q <= src_base;
        cnt_q <= count;
        dst_q <= dst;
        idx_q <= '0;
      end else if (state_q == StRead) begin
        idx_q <= idx_q + 5'd1;
      end
    end
  end

  // Outputs decoded from the current state; the bus idles at zero.
  always_comb begin
    Addr  = '0;
    we    = 1'b0;
    wData = '0;
    busy  = (state_q != StIdle);
    done  = 1'b0;
    unique case (state_q)
      StRead: Addr = rf_addr(rd_idx);
      StWrite: begin
        Addr  = rf_addr(dst_q);
        we    = 1'b1;
        wData = acc_sum;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: doc/rf_sum_ctrl.md
RF_SUM_CTRL -- requirements
Module: rf_sum_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 23, meaning the number of addressable register-file entries (indices 0..22).
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the register data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request pulse, sampled in IDLE only.
REQ-006 The block SHALL have port src_base, input, 5 bits: index of the first operand register.
REQ-007 The block SHALL have port count, input, 5 bits: number of consecutive registers to sum (1..23).
REQ-008 The block SHALL have port dst, input, 5 bits: index of the result register.
REQ-009 The block SHALL have port Addr, output, 16 bits: register-file address, {11'b0, index}.
REQ-010 The block SHALL have port we, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have port wData, output, 64 bits: register-file write data.
REQ-012 The block SHALL have port rData, input, 64 bits: register-file read data, valid one clock after Addr is presented.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected request.
REQ-016 The block SHALL have port ovf, output, 1 bit: carry-out flag of the last completed sum, held until the next accepted start.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, READ, DRAIN, WRITE and DONE.
REQ-018 In IDLE with start=1, a request with count=0, src_base+count-1>22 or dst>22 SHALL be rejected: err=1 for the next cycle, the FSM stays in IDLE, ovf is unchanged and no rf access occurs.
REQ-019 A valid start SHALL latch src_base, count and dst, clear the accumulator and ovf, and enter READ on the next cycle.
REQ-020 In READ, the block SHALL issue Addr=src_base+i for i=0..count-1 on consecutive cycles, one address per cycle, with we=0.
REQ-021 After issuing the last address, the FSM SHALL move READ->DRAIN.
REQ-022 rData SHALL be added to the accumulator on the cycle after each issued address, so count additions occur in total.
REQ-023 The DRAIN state SHALL last one cycle and perform the final addition.
REQ-024 Summation SHALL be modulo 2^64; any carry out of bit 63 on any addition SHALL set the sticky ovf bit for that operation.
REQ-025 In WRITE, for one cycle, the block SHALL drive we=1, Addr=dst and wData=accumulator.
REQ-026 In DONE, for one cycle, the block SHALL drive done=1 and then return to IDLE.
REQ-027 The done pulse SHALL occur count+3 cycles after the cycle in which start was sampled.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 dst MAY equal an operand index; because the write follows all reads, the new value SHALL be written.
REQ-030 When not in READ or WRITE, Addr SHALL be 0, we SHALL be 0 and wData SHALL be 0.

Reset
REQ-031 While reset_n=0, the block SHALL immediately enter IDLE and drive busy=0, done=0, err=0, ovf=0, we=0, Addr=0, wData=0, with the accumulator and latched fields cleared.
REQ-032 Reset asserted mid-operation SHALL abort the operation, and no write SHALL occur after reset is released.

Structure
REQ-033 A shared package SHALL hold NUM_REGS, DATA_W, RF_ADDR_W=16 and the FSM state encoding.
REQ-034 A single sub-module, rf_acc64, SHALL implement the 64-bit accumulator, with clear, add-enable and sticky carry.
REQ-035 The block SHALL connect directly to the register file's Addr, we, wData and rData ports.

Verification
REQ-036 Scenario: preload r3=5, r4=7, r5=9; start with src_base=3, count=3, dst=10 -> r10=21, ovf=0, done exactly 6 cycles after start.
REQ-037 Scenario: r0=64'hFFFF_FFFF_FFFF_FFFF, r1=2; src_base=0, count=2, dst=0 -> r0=1, ovf=1.
REQ-038 Scenario: src_base=20, count=4 -> err pulse, no we, busy stays 0; likewise count=0 and dst=23 are each rejected.
REQ-039 Scenario: count=23, src_base=0, all registers=1, dst=22 -> r22=23, done 26 cycles after start.
REQ-040 Scenario: a second start pulse while busy -> ignored, only one write and one done.
REQ-041 Scenario: reset_n dropped in READ, then released -> IDLE, all outputs 0, and the dst register is unchanged.
